// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution with redirect handshake and counters
// Resolves B-type/JAL/JALR against a prediction; a mispredict holds a redirect until fetch acks.
module branch_resolve #(
  parameter int XLEN      = 32,
  parameter int PRED_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             res_valid,
  output logic             res_branch_en,
  output logic             res_cond,
  output logic             res_taken,
  output logic             res_illegal,
  output logic             res_misalign,
  output logic             link_valid,
  output logic [XLEN-1:0]  link_data,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;

  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT} state_t;

  state_t state_q, state_d;

  logic            is_cond, is_jal, is_jalr, is_branch;
  logic            cond_true, illegal, taken, misalign;
  logic            exp_taken, mispredict, accept;
  logic [XLEN-1:0] jalr_sum, target, exp_target, link;

  always_comb begin
    is_cond   = (opcode == OP_BRANCH);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR);
    is_branch = is_cond | is_jal | is_jalr;

    cond_true = 1'b0;
    illegal   = 1'b0;
    case (func3)
      3'd0:    cond_true = (rs1_val == rs2_val);
      3'd1:    cond_true = (rs1_val != rs2_val);
      3'd4:    cond_true = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5:    cond_true = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    cond_true = (rs1_val <  rs2_val);
      3'd7:    cond_true = (rs1_val >= rs2_val);
      default: illegal   = is_cond;
    endcase

    taken    = (is_cond & cond_true) | is_jal | is_jalr;
    jalr_sum = rs1_val + imm;
    target   = is_jalr ? (jalr_sum & ~XLEN'(1)) : (pc + imm);
    link     = pc + XLEN'(4);
    misalign = taken && (target[1:0] != 2'b00);

    // Static BTFN: backward conditionals and JAL are predicted taken to the exact target.
    if (PRED_MODE == 1) begin
      exp_taken  = is_cond ? imm[XLEN-1] : is_jal;
      exp_target = target;
    end else begin
      exp_taken  = pred_taken;
      exp_target = pred_target;
    end

    // A misaligned taken target is left to the trap path, so it never redirects.
    mispredict = is_branch && !misalign &&
                 ((taken != exp_taken) || (taken && exp_taken && (exp_target != target)));
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d        = state_q;
    in_ready       = (state_q != REDIRECT);
    redirect_valid = (state_q == REDIRECT);
    case (state_q)
      IDLE, RESOLVE: begin
        if (accept) state_d = mispredict ? REDIRECT : RESOLVE;
        else        state_d = IDLE;
      end
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic            res_valid_q, branch_en_q, cond_q, taken_q, illegal_q, misalign_q, link_valid_q;
  logic [XLEN-1:0] link_data_q, redirect_pc_q;

  // Result fields only load on accept, so they hold while no result is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q   <= 1'b0;
      branch_en_q   <= 1'b0;
      cond_q        <= 1'b0;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
      misalign_q    <= 1'b0;
      link_valid_q  <= 1'b0;
      link_data_q   <= '0;
      redirect_pc_q <= '0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        branch_en_q   <= is_branch;
        cond_q        <= is_cond;
        taken_q       <= taken;
        illegal_q     <= illegal;
        misalign_q    <= misalign;
        link_valid_q  <= is_jal | is_jalr;
        link_data_q   <= link;
        redirect_pc_q <= taken ? target : link;
      end
    end
  end

  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (cnt_clr) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (accept && is_branch && (branch_cnt_q != {CNT_W{1'b1}}))
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (accept && mispredict && (mispred_cnt_q != {CNT_W{1'b1}}))
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign res_valid     = res_valid_q;
  assign res_branch_en = branch_en_q;
  assign res_cond      = cond_q;
  assign res_taken     = taken_q;
  assign res_illegal   = illegal_q;
  assign res_misalign  = misalign_q;
  assign link_valid    = link_valid_q;
  assign link_data     = link_data_q;
  assign redirect_pc   = redirect_pc_q;
  assign branch_cnt    = branch_cnt_q;
  assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - random and directed checks of branch_resolve against a reference model
// Instance 0: PRED_MODE 0, CNT_W 16. Instance 1: PRED_MODE 1, CNT_W 2. Both share stimulus.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, redirect_ready = 1'b0, cnt_clr = 1'b0, pred_taken = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] pc = '0, rs1_val = '0, rs2_val = '0, imm = '0, pred_target = '0;

  logic        in_ready_w[2], res_valid_w[2], br_w[2], cond_w[2], taken_w[2];
  logic        ill_w[2], mis_w[2], lv_w[2], rdv_w[2];
  logic [31:0] link_w[2], rpc_w[2];
  logic [15:0] bc0, mc0;
  logic [1:0]  bc1, mc1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .PRED_MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .opcode(opcode), .func3(func3), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid_w[0]), .res_branch_en(br_w[0]), .res_cond(cond_w[0]),
    .res_taken(taken_w[0]), .res_illegal(ill_w[0]), .res_misalign(mis_w[0]),
    .link_valid(lv_w[0]), .link_data(link_w[0]), .redirect_valid(rdv_w[0]),
    .redirect_ready(redirect_ready), .redirect_pc(rpc_w[0]), .cnt_clr(cnt_clr),
    .branch_cnt(bc0), .mispred_cnt(mc0));

  branch_resolve #(.XLEN(32), .PRED_MODE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .opcode(opcode), .func3(func3), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid_w[1]), .res_branch_en(br_w[1]), .res_cond(cond_w[1]),
    .res_taken(taken_w[1]), .res_illegal(ill_w[1]), .res_misalign(mis_w[1]),
    .link_valid(lv_w[1]), .link_data(link_w[1]), .redirect_valid(rdv_w[1]),
    .redirect_ready(redirect_ready), .redirect_pc(rpc_w[1]), .cnt_clr(cnt_clr),
    .branch_cnt(bc1), .mispred_cnt(mc1));

  typedef struct {
    bit          rv, br, cond, taken, ill, mis, lv, redir;
    logic [31:0] link, rpc;
    int          bcnt, mcnt;
  } exp_t;

  exp_t m[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // What one instruction must produce, straight from the architectural rules.
  function automatic exp_t resolve(input int mode);
    exp_t        r;
    logic [31:0] tgt, ptgt;
    bit          pred;
    r = '{default: '0};
    r.br   = (opcode == 7'd99) || (opcode == 7'd111) || (opcode == 7'd103);
    r.cond = (opcode == 7'd99);
    r.lv   = (opcode == 7'd111) || (opcode == 7'd103);
    r.link = pc + 32'd4;
    tgt    = pc + imm;
    if (opcode == 7'd99) begin
      case (func3)
        3'd0: r.taken = (rs1_val == rs2_val);
        3'd1: r.taken = (rs1_val != rs2_val);
        3'd4: r.taken = ($signed(rs1_val) < $signed(rs2_val));
        3'd5: r.taken = ($signed(rs1_val) >= $signed(rs2_val));
        3'd6: r.taken = (rs1_val < rs2_val);
        3'd7: r.taken = (rs1_val >= rs2_val);
        default: r.ill = 1;
      endcase
    end else if (opcode == 7'd111) begin
      r.taken = 1;
    end else if (opcode == 7'd103) begin
      r.taken = 1;
      tgt = (rs1_val + imm) & 32'hFFFF_FFFE;
    end
    if (mode == 0) begin
      pred = pred_taken;
      ptgt = pred_target;
    end else begin
      pred = r.cond ? imm[31] : (opcode == 7'd111);
      ptgt = tgt;
    end
    r.mis   = r.taken && (tgt % 4 != 0);
    r.redir = r.br && !r.mis && ((r.taken != pred) || (r.taken && pred && ptgt != tgt));
    r.rpc   = r.taken ? tgt : pc + 32'd4;
    return r;
  endfunction

  function automatic exp_t model_step(input int d, input exp_t c);
    exp_t n, r;
    bit   acc;
    int   cmax;
    n    = c;
    acc  = in_valid && !c.redir;
    cmax = (d == 1) ? 3 : 65535;
    r    = resolve(d);
    if (c.redir && redirect_ready) n.redir = 0;
    n.rv = acc;
    if (acc) begin
      n.br = r.br; n.cond = r.cond; n.taken = r.taken; n.ill = r.ill;
      n.mis = r.mis; n.lv = r.lv; n.link = r.link; n.rpc = r.rpc; n.redir = r.redir;
    end
    if (cnt_clr) begin
      n.bcnt = 0;
      n.mcnt = 0;
    end else begin
      if (acc && r.br && n.bcnt < cmax) n.bcnt = n.bcnt + 1;
      if (acc && r.redir && n.mcnt < cmax) n.mcnt = n.mcnt + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) m[d] <= '{default: '0};
      else        m[d] <= model_step(d, m[d]);
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [15:0] bc, mc;
      bc = (d == 1) ? {14'b0, bc1} : bc0;
      mc = (d == 1) ? {14'b0, mc1} : mc0;
      chk($sformatf("d%0d.in_ready", d), 64'(in_ready_w[d]), 64'(!m[d].redir));
      chk($sformatf("d%0d.redirect_valid", d), 64'(rdv_w[d]), 64'(m[d].redir));
      chk($sformatf("d%0d.res_valid", d), 64'(res_valid_w[d]), 64'(m[d].rv));
      chk($sformatf("d%0d.branch_cnt", d), 64'(bc), 64'(m[d].bcnt));
      chk($sformatf("d%0d.mispred_cnt", d), 64'(mc), 64'(m[d].mcnt));
      if (m[d].rv) begin
        chk($sformatf("d%0d.res_branch_en", d), 64'(br_w[d]), 64'(m[d].br));
        chk($sformatf("d%0d.res_cond", d), 64'(cond_w[d]), 64'(m[d].cond));
        chk($sformatf("d%0d.res_taken", d), 64'(taken_w[d]), 64'(m[d].taken));
        chk($sformatf("d%0d.res_illegal", d), 64'(ill_w[d]), 64'(m[d].ill));
        chk($sformatf("d%0d.res_misalign", d), 64'(mis_w[d]), 64'(m[d].mis));
        chk($sformatf("d%0d.link_valid", d), 64'(lv_w[d]), 64'(m[d].lv));
        if (m[d].lv) chk($sformatf("d%0d.link_data", d), 64'(link_w[d]), 64'(m[d].link));
      end
      if (m[d].redir) chk($sformatf("d%0d.redirect_pc", d), 64'(rpc_w[d]), 64'(m[d].rpc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic pt, input logic [31:0] ptg);
    opcode = op; func3 = f3; pc = p; rs1_val = a; rs2_val = b; imm = im;
    pred_taken = pt; pred_target = ptg; in_valid = 1'b1;
  endtask

  task automatic flush(input int n);
    in_valid = 1'b0;
    redirect_ready = 1'b1;
    repeat (n) step();
    redirect_ready = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chk("rst.in_ready", 64'(in_ready_w[0]), 64'd1);
    chk("rst.res_valid", 64'(res_valid_w[0]), 64'd0);
    chk("rst.redirect_valid", 64'(rdv_w[0]), 64'd0);
    chk("rst.redirect_pc", 64'(rpc_w[0]), 64'd0);
    chk("rst.link_data", 64'(link_w[0]), 64'd0);
    chk("rst.branch_cnt", 64'(bc0), 64'd0);
    rst_n = 1'b1;
    step();

    // BEQ taken against a not-taken prediction, redirect stalled for three cycles.
    drive(7'd99, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    chk("t1.res_valid", 64'(res_valid_w[0]), 64'd1);
    chk("t1.res_taken", 64'(taken_w[0]), 64'd1);
    chk("t1.redirect_valid", 64'(rdv_w[0]), 64'd1);
    chk("t1.redirect_pc", 64'(rpc_w[0]), 64'h120);
    chk("t1.mispred_cnt", 64'(mc0), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1.in_ready_stall", 64'(in_ready_w[0]), 64'd0);
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("t1.in_ready_after_ack", 64'(in_ready_w[0]), 64'd1);

    // Signed vs unsigned compare, back-to-back correctly predicted.
    drive(7'd99, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h210);
    step();
    drive(7'd99, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    chk("t2.blt_valid", 64'(res_valid_w[0]), 64'd1);
    chk("t2.blt_taken", 64'(taken_w[0]), 64'd1);
    chk("t2.blt_redirect", 64'(rdv_w[0]), 64'd0);
    step();
    in_valid = 1'b0;
    chk("t2.bltu_valid", 64'(res_valid_w[0]), 64'd1);
    chk("t2.bltu_taken", 64'(taken_w[0]), 64'd0);
    chk("t2.bltu_redirect", 64'(rdv_w[0]), 64'd0);
    flush(2);

    // JALR to a misaligned target: trap case, no redirect.
    drive(7'd103, 3'd0, 32'h40, 32'h1001, 32'd0, 32'h2, 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    chk("t3.misalign", 64'(mis_w[0]), 64'd1);
    chk("t3.link_valid", 64'(lv_w[0]), 64'd1);
    chk("t3.link_data", 64'(link_w[0]), 64'h44);
    chk("t3.redirect_valid", 64'(rdv_w[0]), 64'd0);
    flush(2);

    // Static BTFN: backward BNE predicted taken, forward BNE redirects.
    drive(7'd99, 3'd1, 32'h300, 32'd1, 32'd2, 32'hFFFF_FFF8, 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    chk("t4.back_taken", 64'(taken_w[1]), 64'd1);
    chk("t4.back_redirect", 64'(rdv_w[1]), 64'd0);
    flush(2);
    drive(7'd99, 3'd1, 32'h300, 32'd1, 32'd2, 32'h8, 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    chk("t4.fwd_redirect", 64'(rdv_w[1]), 64'd1);
    chk("t4.fwd_redirect_pc", 64'(rpc_w[1]), 64'h308);
    flush(2);

    // JAL wrapping at the top of the address space, then an illegal func3.
    drive(7'd111, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    chk("t5.jal_link_data", 64'(link_w[0]), 64'h0);
    chk("t5.jal_redirect_pc", 64'(rpc_w[0]), 64'h4);
    chk("t5.jal_redirect", 64'(rdv_w[0]), 64'd1);
    flush(2);
    drive(7'd99, 3'd2, 32'h500, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    chk("t5.illegal", 64'(ill_w[0]), 64'd1);
    chk("t5.illegal_taken", 64'(taken_w[0]), 64'd0);
    chk("t5.illegal_redirect", 64'(rdv_w[0]), 64'd0);
    flush(2);

    // Two-bit counters: saturation, clear priority, reset during redirect.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t6.cleared", 64'(bc1), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(7'd111, 3'd0, 32'h600, 32'd0, 32'd0, 32'h10, 1'b1, 32'h610);
      step();
    end
    in_valid = 1'b0;
    chk("t6.saturated", 64'(bc1), 64'd3);
    drive(7'd111, 3'd0, 32'h600, 32'd0, 32'd0, 32'h10, 1'b1, 32'h610);
    cnt_clr = 1'b1;
    step();
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    chk("t6.clr_wins", 64'(bc1), 64'd0);
    chk("t6.clr_res_valid", 64'(res_valid_w[1]), 64'd1);
    drive(7'd103, 3'd0, 32'h700, 32'h800, 32'd0, 32'd0, 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    chk("t6.in_redirect", 64'(rdv_w[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst_redirect_valid", 64'(rdv_w[1]), 64'd0);
    chk("t6.rst_in_ready", 64'(in_ready_w[1]), 64'd1);
    chk("t6.rst_redirect_valid_d0", 64'(rdv_w[0]), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      int          t;
      logic [31:0] v;
      r = $urandom_range(0, 9);
      opcode = (r < 5) ? 7'd99 : (r < 7) ? 7'd111 : (r < 9) ? 7'd103 : 7'($urandom);
      func3 = 3'($urandom);
      v = $urandom;
      pc = v & 32'hFFFF_FFFC;
      rs1_val = $urandom;
      rs2_val = ($urandom_range(0, 3) == 0) ? rs1_val : 32'($urandom);
      t = int'($urandom_range(0, 511)) - 256;
      imm = 32'(t);
      if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
      if (opcode == 7'd103 && $urandom_range(0, 1) == 1) rs1_val = rs1_val & 32'hFFFF_FFFC;
      pred_taken = 1'($urandom);
      pred_target = ($urandom_range(0, 1) == 1) ? pc + imm : 32'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      redirect_ready = ($urandom_range(0, 2) != 0);
      cnt_clr = ($urandom_range(0, 63) == 0);
      step();
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    redirect_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Registered branch resolution unit for the execute stage. It generalises per-opcode branch decoding into an XLEN-parametrised block that:
- classifies and evaluates B-type, JAL and JALR instructions;
- computes targets and link values;
- compares the outcome against a prediction and holds a redirect handshake toward fetch until it is acknowledged;
- keeps saturating branch and mispredict counters.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- PRED_MODE, 0, prediction source: 0 uses `pred_taken`/`pred_target` inputs; 1 uses static BTFN
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept; equals (state != REDIRECT)
- opcode  in  7  instruction opcode
- func3  in  3  branch condition select
- pc  in  XLEN  instruction PC
- rs1_val, rs2_val  in  XLEN each  operands
- imm  in  XLEN  sign-extended offset
- pred_taken  in  1  fetch prediction (PRED_MODE 0 only)
- pred_target  in  XLEN  predicted target (PRED_MODE 0 only)
- res_valid  out  1  one-cycle pulse; result of the previously accepted instruction
- res_branch_en, res_cond, res_taken  out  1 each  is branch; is conditional; resolved taken
- res_illegal  out  1  opcode 99 with func3 2 or 3
- res_misalign  out  1  taken with target[1:0] != 0
- link_valid  out  1  JAL/JALR result; rd write required
- link_data  out  XLEN  pc+4
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch acknowledge
- redirect_pc  out  XLEN  correct next PC
- cnt_clr  in  1  synchronous clear of both counters
- branch_cnt, mispred_cnt  out  CNT_W each  saturating counters

## Operation
Classification by opcode:
- 99: branch, conditional.
- 111: JAL.
- 103: JALR.
- Anything else: non-branch. It is still accepted and produces `res_valid` with all flags 0.

Conditions:
- func3 0 EQ, 1 NE, 4 LT signed, 5 GE signed, 6 LTU, 7 GEU.
- func3 2/3: not taken, `res_illegal`=1.

Targets:
- B-type and JAL: pc+imm.
- JALR: (rs1_val+imm) with bit 0 cleared.
- All adds wrap modulo 2^XLEN, including link_data at PC 2^XLEN-4, which gives 0.

Prediction:
- PRED_MODE 0: predicted = `pred_taken`.
- PRED_MODE 1: conditional predicted taken iff imm[XLEN-1]; JAL predicted taken to its exact target; JALR predicted not taken.

Mispredict:
- Branch instructions only: actual != predicted, or both taken with predicted target != actual target.
- Mode 1 compares against the exact computed target.
- `res_misalign` suppresses the redirect; trap logic owns that case.
- `redirect_pc` = target if taken, else pc+4.

State machine:
- IDLE: no result pending.
- RESOLVE: result registered, `res_valid`=1 for exactly this cycle.
- REDIRECT: `redirect_valid`=1, `in_ready`=0.

Transitions:
- IDLE or RESOLVE with in_valid&&in_ready -> RESOLVE, or REDIRECT if mispredict.
- No accept -> IDLE.
- Entry into REDIRECT also pulses `res_valid` in its first cycle.
- REDIRECT with redirect_ready -> IDLE.
- REDIRECT holds `redirect_pc` stable until acknowledged.

Counters:
- branch_cnt increments on each accepted branch; mispred_cnt on each mispredict.
- Both saturate at 2^CNT_W-1.
- cnt_clr wins over a same-cycle increment.

## Timing
- Reset: every output 0 except `in_ready`=1; state IDLE.
- Reset assertion mid-REDIRECT drops `redirect_valid` asynchronously; no redirect replay.
- Latency: accept at edge T; results and `redirect_valid` visible in cycle T+1.
- Throughput: one instruction per cycle with no mispredicts.
- Mispredict cost: `redirect_ready` sampled high in cycle T+1 -> `in_ready` high in T+2. Each extra stall cycle of `redirect_ready` adds one cycle.
- Result fields hold their last value while `res_valid`=0. Consumers must use `res_valid` as qualifier.
- Counter value updates are visible the cycle after the event.

## Test plan
1. BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 (mode 0) -> T+1: res_taken=1, redirect_valid=1, redirect_pc=0x120, mispred_cnt=1. Hold redirect_ready low 3 cycles -> in_ready low throughout.
2. BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken. pred_taken matched in both -> no redirect, two back-to-back res_valid pulses.
3. JALR rs1=0x1001, imm=0x2, pc=0x40 -> target 0x1002, res_misalign=1, link_data=0x44, no redirect.
4. PRED_MODE 1, BNE taken with imm=-8 (predicted taken) -> no redirect. Same with imm=+8 -> redirect_pc=pc+8.
5. JAL at pc=0xFFFFFFFC, imm=8 -> target 0x4, link_data=0. Drive func3=2 on opcode 99 -> res_illegal=1, not taken.
6. CNT_W=2: 5 branches -> branch_cnt=3 (saturated). cnt_clr together with a branch -> 0. rst_n low during REDIRECT -> redirect_valid=0 immediately, in_ready=1.
